// File: rtl/regfile_pkg.sv
// Shared constants and the pending-write entry type for the register-file
// write-back front end.
package regfile_pkg;
   localparam int NREGS    = 32;
   localparam int WIDTH    = 64;
   localparam int ZERO_REG = 31;
   localparam int REG_AW   = $clog2(NREGS);

   localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

   typedef struct packed {
      logic [REG_AW-1:0] addr;
      logic [WIDTH-1:0]  data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes. Entries are presented
// oldest-first (index 0 is the head) so the forwarding search can scan by age.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  wb_entry_t                  i_entry,
   output wb_entry_t [DEPTH-1:0]      o_entries,
   output logic      [DEPTH-1:0]      o_valid,
   output wb_entry_t                  o_head,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t [DEPTH-1:0] r_mem;
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Power-of-two depth lets the pointer arithmetic wrap for free.
   for (genvar g = 0; g < DEPTH; g++) begin : g_age
      logic [PW-1:0] w_idx;
      assign w_idx        = r_rd_ptr + PW'(g);
      assign o_entries[g] = r_mem[w_idx];
      assign o_valid[g]   = (CW'(g) < r_count);
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back front end: buffers pipeline register writes, drains one per
// cycle into the storage next-state vector, and forwards pending writes to reads.
module regfile_wb_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [REG_AW-1:0]            wr_addr,
   input  logic [WIDTH-1:0]             wr_data,
   input  logic [REG_AW-1:0]            rd_addr_a,
   output logic [WIDTH-1:0]             rd_data_a,
   input  logic [REG_AW-1:0]            rd_addr_b,
   output logic [WIDTH-1:0]             rd_data_b,
   input  logic [NREGS-1:0][WIDTH-1:0]  q_in,
   output logic [NREGS-1:0][WIDTH-1:0]  d_out,
   output logic [$clog2(DEPTH):0]       pending
);
   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t [DEPTH-1:0] w_entries;
   logic      [DEPTH-1:0] w_valid;
   wb_entry_t             w_head;
   wb_entry_t             w_new;
   logic [CW-1:0]         w_count;
   logic                  w_push;
   logic                  w_pop;

   // Handshake: a write transfers on a posedge where wr_valid && wr_ready;
   // wr_ready depends only on registered occupancy, never on wr_valid or the
   // concurrent drain, so a full FIFO refuses even while an entry is leaving.
   assign wr_ready = reset && (w_count < CW'(DEPTH));
   assign w_push   = wr_valid && wr_ready && (wr_addr != ZERO_ADDR);
   assign w_pop    = reset && (w_count != '0);
   assign w_new    = '{addr: wr_addr, data: wr_data};
   assign pending  = w_count;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_entry   (w_new),
      .o_entries (w_entries),
      .o_valid   (w_valid),
      .o_head    (w_head),
      .o_count   (w_count)
   );

   // Holding reset zeroes d_out so the storage clears on the same edge.
   always_comb begin
      d_out = q_in;
      if (!reset) begin
         d_out = '0;
      end else if (w_pop) begin
         d_out[w_head.addr] = w_head.data;
      end
   end

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      rd_data_a = q_in[rd_addr_a];
      rd_data_b = q_in[rd_addr_b];
      for (int j = 0; j < DEPTH; j++) begin
         if (w_valid[j] && (w_entries[j].addr == rd_addr_a)) rd_data_a = w_entries[j].data;
         if (w_valid[j] && (w_entries[j].addr == rd_addr_b)) rd_data_b = w_entries[j].data;
      end
      if (rd_addr_a == ZERO_ADDR) rd_data_a = '0;
      if (rd_addr_b == ZERO_ADDR) rd_data_b = '0;
   end
endmodule
